// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode/funct constants and the datapath mux select codes.
package multicycle_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH      = 5'd0,
        S_FETCH_WAIT = 5'd1,
        S_IR_LOAD    = 5'd2,
        S_DECODE     = 5'd3,
        S_ADDR       = 5'd4,
        S_LW_WAIT    = 5'd5,
        S_LW_MDR     = 5'd6,
        S_LW_WB      = 5'd7,
        S_SW_WRITE   = 5'd8,
        S_ADDI_WB    = 5'd9,
        S_R_EXEC     = 5'd10,
        S_R_WB       = 5'd11,
        S_BRANCH     = 5'd12,
        S_JUMP       = 5'd13,
        S_HALT       = 5'd14,
        S_TRAP       = 5'd15
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Special R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_BREAK = 6'b001101;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    // ALU operation select
    localparam logic [1:0] ULAOP_ADD   = 2'b00;
    localparam logic [1:0] ULAOP_SUB   = 2'b01;
    localparam logic [1:0] ULAOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ULAB_REG    = 2'b00;
    localparam logic [1:0] ULAB_FOUR   = 2'b01;
    localparam logic [1:0] ULAB_IMM    = 2'b10;
    localparam logic [1:0] ULAB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_timer.sv
// mem_wait_timer: counts memory wait cycles. Cleared before each wait phase,
// incremented while waiting; 'done' flags the last of MEM_WAIT wait cycles.
module mem_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int MEM_WAIT = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic count,
    output logic done
);

    // Index of the final wait cycle; irrelevant when MEM_WAIT is 0 because
    // the FSM then skips the wait states entirely.
    localparam int LAST = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;

    if (MEM_WAIT < 0 || MEM_WAIT >= (1 << WAIT_W)) begin : g_bad_wait
        $error("mem_wait_timer: MEM_WAIT does not fit in WAIT_W bits");
    end

    logic [WAIT_W-1:0] cnt;

    // Wait counter: synchronous active-low reset, clear has priority over count
    always_ff @(posedge Clock) begin
        if (!Reset || clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

    assign done = (cnt == WAIT_W'(LAST));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/write-back
// for the multicycle MIPS datapath. Memory latency is MEM_WAIT counted cycles,
// or, when the MEM_READY_HS_EN macro is defined, a MemReady handshake.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int WAIT_W   = 4,
    parameter int STATE_W  = 5
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
`ifdef MEM_READY_HS_EN
    input  logic               MemReady,
`endif
    output logic               PCEsc,
    output logic               PCEscCond,
    output logic               PCEscCondBNE,
    output logic               IouD,
    output logic               CtrMem,
    output logic               IREsc,
    output logic               MDRCtrl,
    output logic               RegACtrl,
    output logic               RegBCtrl,
    output logic               ULASaidaCtrl,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemParaReg,
    output logic               ULAFonteA,
    output logic [1:0]         ULAFonteB,
    output logic [1:0]         FontePC,
    output logic [1:0]         ULAOp,
    output logic [STATE_W-1:0] State,
    output logic               Halted,
    output logic               IllegalOp
);

    state_t state;
    state_t next_state;
    logic   tmr_clear;
    logic   tmr_count;
    logic   tmr_done;
    logic   wait_done;

    mem_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MEM_WAIT (MEM_WAIT)
    ) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .clear (tmr_clear),
        .count (tmr_count),
        .done  (tmr_done)
    );

`ifdef MEM_READY_HS_EN
    assign wait_done = MemReady;
`else
    assign wait_done = tmr_done;
`endif

    assign State = STATE_W'(state);

    // State register: synchronous active-low reset returns to FETCH from anywhere
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state dispatch and Moore outputs; unused encodings fall to FETCH with outputs low
    always_comb begin
        next_state   = S_FETCH;
        tmr_clear    = 1'b0;
        tmr_count    = 1'b0;
        PCEsc        = 1'b0;
        PCEscCond    = 1'b0;
        PCEscCondBNE = 1'b0;
        IouD         = 1'b0;
        CtrMem       = 1'b0;
        IREsc        = 1'b0;
        MDRCtrl      = 1'b0;
        RegACtrl     = 1'b0;
        RegBCtrl     = 1'b0;
        ULASaidaCtrl = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemParaReg   = 1'b0;
        ULAFonteA    = 1'b0;
        ULAFonteB    = ULAB_REG;
        FontePC      = PC_ALU;
        ULAOp        = ULAOP_ADD;
        Halted       = 1'b0;
        IllegalOp    = 1'b0;

        case (state)
            S_FETCH: begin
                tmr_clear = 1'b1;
`ifdef MEM_READY_HS_EN
                next_state = S_FETCH_WAIT;
`else
                next_state = (MEM_WAIT == 0) ? S_IR_LOAD : S_FETCH_WAIT;
`endif
            end
            S_FETCH_WAIT: begin
                tmr_count  = 1'b1;
                next_state = wait_done ? S_IR_LOAD : S_FETCH_WAIT;
            end
            S_IR_LOAD: begin
                IREsc      = 1'b1;
                PCEsc      = 1'b1;
                ULAFonteB  = ULAB_FOUR;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                RegACtrl     = 1'b1;
                RegBCtrl     = 1'b1;
                ULAFonteB    = ULAB_IMM_SH;
                ULASaidaCtrl = 1'b1;
                if (OpCode == OP_R) begin
                    if (Funct == FN_BREAK) begin
                        next_state = S_HALT;
                    end else if (Funct == FN_NOP) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_R_EXEC;
                    end
                end else if (OpCode == OP_LW || OpCode == OP_SW || OpCode == OP_ADDI) begin
                    next_state = S_ADDR;
                end else if (OpCode == OP_BEQ || OpCode == OP_BNE) begin
                    next_state = S_BRANCH;
                end else if (OpCode == OP_J) begin
                    next_state = S_JUMP;
                end else begin
                    next_state = S_TRAP;
                end
            end
            S_ADDR: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = ULAB_IMM;
                ULASaidaCtrl = 1'b1;
                tmr_clear    = 1'b1;
                if (OpCode == OP_LW) begin
`ifdef MEM_READY_HS_EN
                    next_state = S_LW_WAIT;
`else
                    next_state = (MEM_WAIT == 0) ? S_LW_MDR : S_LW_WAIT;
`endif
                end else if (OpCode == OP_SW) begin
                    next_state = S_SW_WRITE;
                end else if (OpCode == OP_ADDI) begin
                    next_state = S_ADDI_WB;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_LW_WAIT: begin
                IouD       = 1'b1;
                tmr_count  = 1'b1;
                next_state = wait_done ? S_LW_MDR : S_LW_WAIT;
            end
            S_LW_MDR: begin
                IouD       = 1'b1;
                MDRCtrl    = 1'b1;
                next_state = S_LW_WB;
            end
            S_LW_WB: begin
                RegWrite   = 1'b1;
                MemParaReg = 1'b1;
                next_state = S_FETCH;
            end
            S_SW_WRITE: begin
                IouD   = 1'b1;
                CtrMem = 1'b1;
`ifdef MEM_READY_HS_EN
                next_state = MemReady ? S_FETCH : S_SW_WRITE;
`else
                next_state = S_FETCH;
`endif
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_R_EXEC: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = ULAB_REG;
                ULAOp        = ULAOP_FUNCT;
                ULASaidaCtrl = 1'b1;
                next_state   = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = ULAB_REG;
                ULAOp        = ULAOP_SUB;
                FontePC      = PC_ALUOUT;
                PCEscCond    = (OpCode == OP_BEQ);
                PCEscCondBNE = (OpCode == OP_BNE);
                next_state   = S_FETCH;
            end
            S_JUMP: begin
                PCEsc      = 1'b1;
                FontePC    = PC_JUMP;
                next_state = S_FETCH;
            end
            S_HALT: begin
                Halted     = 1'b1;
                next_state = S_HALT;
            end
            S_TRAP: begin
                IllegalOp  = 1'b1;
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: three instances (MEM_WAIT = 0, 2, 3)
// run directed and random instructions; a reference model predicts the
// per-cycle state trace and output vector, and a monitor compares them.
module tb_multicycle_ctrl;

    localparam logic [5:0] M_LW   = 6'h23;
    localparam logic [5:0] M_SW   = 6'h2b;
    localparam logic [5:0] M_ADDI = 6'h08;
    localparam logic [5:0] M_BEQ  = 6'h04;
    localparam logic [5:0] M_BNE  = 6'h05;
    localparam logic [5:0] M_J    = 6'h02;

    typedef struct {
        int         s;
        logic [5:0] o;
        int         k;
    } item_t;

    logic       clk = 1'b0;
    logic       rst [3];
    logic [5:0] op  [3];
    logic [5:0] fn  [3];

    wire        pcesc [3], pcc [3], pccbne [3], iord [3], ctrmem [3], iresc [3];
    wire        mdr [3], rega [3], regb [3], alus [3], regw [3], regdst [3];
    wire        memreg [3], fa [3], halted [3], illegal [3];
    wire [1:0]  fb [3], fpc [3], aluop [3];
    wire [4:0]  st [3];

    item_t sbq[$];
    int    checks = 0;
    int    fails  = 0;
    int    act    = -1;
    bit    stuck  = 1'b0;
    int    instr_no = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_ctrl #(
            .MEM_WAIT ((g == 0) ? 0 : g + 1),
            .WAIT_W   (4),
            .STATE_W  (5)
        ) u_dut (
            .Clock        (clk),
            .Reset        (rst[g]),
            .OpCode       (op[g]),
            .Funct        (fn[g]),
            .PCEsc        (pcesc[g]),
            .PCEscCond    (pcc[g]),
            .PCEscCondBNE (pccbne[g]),
            .IouD         (iord[g]),
            .CtrMem       (ctrmem[g]),
            .IREsc        (iresc[g]),
            .MDRCtrl      (mdr[g]),
            .RegACtrl     (rega[g]),
            .RegBCtrl     (regb[g]),
            .ULASaidaCtrl (alus[g]),
            .RegWrite     (regw[g]),
            .RegDst       (regdst[g]),
            .MemParaReg   (memreg[g]),
            .ULAFonteA    (fa[g]),
            .ULAFonteB    (fb[g]),
            .FontePC      (fpc[g]),
            .ULAOp        (aluop[g]),
            .State        (st[g]),
            .Halted       (halted[g]),
            .IllegalOp    (illegal[g])
        );
    end

    function automatic int wof(int g);
        return (g == 0) ? 0 : g + 1;
    endfunction

    function automatic logic [21:0] act_outs(int g);
        return {pcesc[g], pcc[g], pccbne[g], iord[g], ctrmem[g], iresc[g], mdr[g],
                rega[g], regb[g], alus[g], regw[g], regdst[g], memreg[g], fa[g],
                fb[g], fpc[g], aluop[g], halted[g], illegal[g]};
    endfunction

    // Output vector each state must present, straight from the state table
    function automatic logic [21:0] exp_outs(int s, logic [5:0] o);
        logic pce = 0, c_eq = 0, c_ne = 0, iod = 0, wr = 0, ir = 0, md = 0;
        logic ra = 0, rb = 0, ao = 0, rw = 0, rd = 0, m2r = 0, a = 0, h = 0, il = 0;
        logic [1:0] b = 2'b00, pc = 2'b00, alu = 2'b00;
        case (s)
            2:  begin ir = 1; pce = 1; b = 2'b01; end
            3:  begin ra = 1; rb = 1; b = 2'b11; ao = 1; end
            4:  begin a = 1; b = 2'b10; ao = 1; end
            5:  iod = 1;
            6:  begin iod = 1; md = 1; end
            7:  begin rw = 1; m2r = 1; end
            8:  begin iod = 1; wr = 1; end
            9:  rw = 1;
            10: begin a = 1; alu = 2'b10; ao = 1; end
            11: begin rw = 1; rd = 1; end
            12: begin a = 1; alu = 2'b01; pc = 2'b01; c_eq = (o == M_BEQ); c_ne = (o == M_BNE); end
            13: begin pce = 1; pc = 2'b10; end
            14: h = 1;
            15: il = 1;
            default: ;
        endcase
        return {pce, c_eq, c_ne, iod, wr, ir, md, ra, rb, ao, rw, rd, m2r, a, b, pc, alu, h, il};
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return (o == 6'h00) || (o == M_LW) || (o == M_SW) || (o == M_ADDI) ||
               (o == M_BEQ) || (o == M_BNE) || (o == M_J);
    endfunction

    // Monitor: pop one expected cycle per falling edge and compare
    always @(negedge clk) begin : mon
        item_t it;
        if (sbq.size() != 0) begin
            it = sbq.pop_front();
            checks++;
            if (st[act] !== 5'(it.s)) begin
                fails++;
                $display("FAIL state inst%0d step%0d dut%0d: got %0d expected %0d",
                         instr_no, it.k, act, st[act], it.s);
            end
            checks++;
            if (act_outs(act) !== exp_outs(it.s, it.o)) begin
                fails++;
                $display("FAIL outputs inst%0d step%0d dut%0d state%0d: got %b expected %b",
                         instr_no, it.k, act, it.s, act_outs(act), exp_outs(it.s, it.o));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d items left, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Leaves the chosen instance in its first FETCH cycle, resetting it when needed
    task automatic begin_instr(int g);
        drain();
        if (g != act || stuck) begin
            act    = g;
            rst[g] = 1'b0;
            @(posedge clk);
            #1;
            rst[g] = 1'b1;
            stuck  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Predict the state trace of one instruction; limit > 0 cuts it short and
    // forces a reset from wherever the trace stopped.
    task automatic issue(int g, logic [5:0] o, logic [5:0] f, int limit);
        int w = wof(g);
        int seq[$];
        begin_instr(g);
        instr_no++;
        op[g] = o;
        fn[g] = f;
        seq.push_back(0);
        repeat (w) seq.push_back(1);
        seq.push_back(2);
        seq.push_back(3);
        if (o == 6'h00 && f == 6'h0d) begin
            repeat (20) seq.push_back(14);
            stuck = 1'b1;
        end else if (o == 6'h00 && f == 6'h00) begin
        end else if (o == 6'h00) begin
            seq.push_back(10); seq.push_back(11);
        end else if (o == M_LW) begin
            seq.push_back(4);
            repeat (w) seq.push_back(5);
            seq.push_back(6); seq.push_back(7);
        end else if (o == M_SW) begin
            seq.push_back(4); seq.push_back(8);
        end else if (o == M_ADDI) begin
            seq.push_back(4); seq.push_back(9);
        end else if (o == M_BEQ || o == M_BNE) begin
            seq.push_back(12);
        end else if (o == M_J) begin
            seq.push_back(13);
        end else begin
            repeat (20) seq.push_back(15);
            stuck = 1'b1;
        end
        if (limit > 0 && limit < seq.size()) begin
            while (seq.size() > limit) void'(seq.pop_back());
            stuck = 1'b1;
        end
        foreach (seq[i]) sbq.push_back('{s: seq[i], o: o, k: i + 1});
    endtask

    initial begin
        logic [5:0] o, f;
        int g, c, lim;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            op[i]  = 6'h00;
            fn[i]  = 6'h00;
        end
        repeat (3) @(posedge clk);
        #1;

        issue(1, 6'h00, 6'h20, 0);   // add, W=2: 0,1,1,2,3,10,11
        issue(0, M_LW, 6'h00, 0);    // lw, W=0: 0,2,3,4,6,7
        issue(2, M_BNE, 6'h00, 0);   // bne, W=3: BRANCH on cycle 7
        issue(2, M_BEQ, 6'h00, 0);
        issue(2, 6'h3f, 6'h00, 0);   // illegal opcode -> TRAP for 20 cycles
        issue(2, 6'h00, 6'h22, 0);   // after reset: FETCH with outputs low
        issue(1, 6'h00, 6'h0d, 0);   // break -> HALT
        issue(1, M_LW, 6'h00, 7);    // stop in first LW_WAIT cycle, then reset
        issue(1, M_LW, 6'h00, 0);    // full lw proves the wait count restarted
        issue(1, M_SW, 6'h00, 0);
        issue(1, M_ADDI, 6'h00, 0);
        issue(1, M_J, 6'h00, 0);
        issue(1, 6'h00, 6'h00, 0);   // nop
        issue(0, 6'h00, 6'h00, 0);

        for (int n = 0; n < 60; n++) begin
            g = $urandom_range(0, 2);
            c = $urandom_range(0, 19);
            f = 6'($urandom_range(0, 63));
            case (c)
                0, 1, 2: begin
                    o = 6'h00;
                    while (f == 6'h00 || f == 6'h0d) f = 6'($urandom_range(0, 63));
                end
                3:         begin o = 6'h00; f = 6'h00; end
                4, 5, 6:   o = M_LW;
                7, 8:      o = M_SW;
                9, 10:     o = M_ADDI;
                11, 12:    o = M_BEQ;
                13, 14:    o = M_BNE;
                15, 16:    o = M_J;
                17:        begin o = 6'h00; f = 6'h0d; end
                default: begin
                    o = 6'($urandom_range(0, 63));
                    while (is_legal(o)) o = 6'($urandom_range(0, 63));
                end
            endcase
            lim = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0;
            issue(g, o, f, lim);
        end

        drain();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
